n1_accum_seq: RTL

- Sequencing and accumulator-register stage wrapped around the single-lane n1 multiply/add datapath.
- Accepts a stream of (nbin, sb) operand pairs under a valid/ready handshake and feeds them to n1 one pair per cycle.
- Drives n1's nbout input from an internal partial-sum register and captures n1's o_res back into that register.
- After a programmed number of terms, presents the finished neuron sum on an output handshake; this is the NBout-side stage directly downstream of n1.

---
 rtl/n1_accum_seq.sv | 107 ++++++++++
 1 files changed

// File: rtl/n1_accum_seq.sv
// n1_accum_seq
//   Sequencing and partial-sum stage around the single-lane n1 multiply/add
//   datapath. It takes a stream of (nbin, sb) operand pairs and presents one
//   pair per cycle to n1. It feeds n1's nbout from the internal partial-sum
//   register and captures n1's combinational result back into that register.
//   After the programmed number of terms, the finished neuron sum is offered
//   on an output valid/ready handshake.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   i_start, i_len,     start a neuron with i_len terms and initial sum
//   i_bias              i_bias (all sampled only in IDLE)
//   i_in_valid,         operand-pair handshake; o_in_ready is high only
//   o_in_ready          while accumulating
//   i_nbin, i_sb        operand pair from upstream
//   o_nbin, o_sb,       to n1: pass-through operands and current partial sum
//   o_nbout
//   i_res               from n1: nbout + nbin*sb, modulo 2^N
//   o_out_valid,        finished-sum handshake
//   i_out_ready,
//   o_out_data
//   o_busy              high whenever a neuron is in progress (not IDLE)
module n1_accum_seq #(
  parameter int N  = 16,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [LW-1:0] i_len,
  input  logic [N-1:0]  i_bias,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [N-1:0]  i_nbin,
  input  logic [N-1:0]  i_sb,
  output logic [N-1:0]  o_nbin,
  output logic [N-1:0]  o_sb,
  output logic [N-1:0]  o_nbout,
  input  logic [N-1:0]  i_res,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [N-1:0]  o_out_data,
  output logic          o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  acc, acc_nxt;
  logic [LW-1:0] remaining, remaining_nxt;

  // n1 sits combinationally between o_nbin/o_sb/o_nbout and i_res, so a
  // whole multiply/add closes in one cycle and pairs stream without bubbles.
  assign o_nbin     = i_nbin;
  assign o_sb       = i_sb;
  assign o_nbout    = acc;
  assign o_out_data = acc;

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    remaining_nxt = remaining;
    o_in_ready    = 1'b0;
    o_out_valid   = 1'b0;
    o_busy        = (state != IDLE);
    case (state)
      IDLE: begin
        if (i_start) begin
          acc_nxt       = i_bias;
          remaining_nxt = i_len;
          state_nxt     = (i_len != '0) ? ACCUM : DONE;
        end
      end
      ACCUM: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          acc_nxt       = i_res;
          remaining_nxt = remaining - LW'(1);
          if (remaining == LW'(1)) state_nxt = DONE;
        end
      end
      DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Partial-sum register: state, sum and term count update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      remaining <= remaining_nxt;
    end
  end

endmodule
